// File: rtl/rf_regfile_mp_pkg.sv
// Shared defaults and types for the multi-port register file.
// The top module's WD/NREG/NRD parameters default to the values here.
package RF_my_pkg;

  localparam int WD       = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  typedef logic [WD-1:0] word_t;

endpackage : RF_my_pkg

// File: rtl/rf_regfile_mp_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, set wins a tie.
// Register 0 is held non-busy when it is the hardwired-zero register.
module rf_scoreboard #(
  parameter int NREG     = RF_my_pkg::NREG_DEF,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_next;

  // NOTE: every signal written in always_comb is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (we)       busy_next[waddr]      = 1'b0;
    // Applied after the clear so a same-cycle issue keeps the newer producer pending.
    if (issue_en) busy_next[issue_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  // NOTE: state in always_ff uses non-blocking (<=) so all registers update together at the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

endmodule : rf_scoreboard

// File: rtl/rf_regfile_mp.sv
// Multi-port register file with asynchronous reads, one synchronous write port,
// optional write-first forwarding, optional hardwired-zero register 0, and a busy scoreboard.
module rf_regfile_mp #(
  parameter  int WD       = RF_my_pkg::WD,
  parameter  int NREG     = RF_my_pkg::NREG_DEF,
  parameter  int NRD      = RF_my_pkg::NRD_DEF,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WD-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*WD-1:0] rdata,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  output logic [NREG-1:0]   busy,
  output logic [NRD-1:0]    rd_busy,
  output logic              any_busy
);

  import RF_my_pkg::*;

  // Local word type follows the WD parameter, which may differ from the package default.
  typedef logic [WD-1:0] word_t;

  word_t mem [NREG];
  logic  wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (waddr == '0);

  // NOTE: the storage array sits on the asynchronous reset because every word must read 0 straight after reset; without that requirement it would be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else if (we && !wr_zero) begin
      mem[waddr] <= wdata;
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .we         (we),
    .waddr      (waddr),
    .busy       (busy)
  );

  assign any_busy = |busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          wr_hit;
    logic          iss_hit;
    word_t         rd;

    assign ra      = raddr[i*AW +: AW];
    assign wr_hit  = we && (waddr == ra);
    assign iss_hit = issue_en && (issue_addr == ra);

    always_comb begin
      rd = mem[ra];
      if ((BYPASS != 0) && wr_hit && !wr_zero) rd = wdata;
      if ((ZERO_REG != 0) && (ra == '0))        rd = '0;
      if (!reset)                               rd = '0;
    end

    assign rdata[i*WD +: WD] = rd;

    // A same-cycle write-back satisfies the operand unless the register is re-issued in that cycle.
    assign rd_busy[i] = reset && busy[ra] &&
                        !((BYPASS != 0) && wr_hit && !iss_hit);
  end

endmodule : rf_regfile_mp

// File: tb/tb_rf_regfile_mp.sv
// Directed and randomized-vs-model checks of rf_regfile_mp in three configurations:
// default (bypass, zero reg), no-bypass, and a small 8x16 three-read-port file.
module tb_rf_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Configurations A (BYPASS=1) and B (BYPASS=0) share one stimulus set.
  logic        we, issue_en;
  logic [4:0]  waddr, issue_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [31:0] busy_a, busy_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        any_busy_a, any_busy_b;

  rf_regfile_mp #(.WD(32), .NREG(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .issue_en(issue_en), .issue_addr(issue_addr),
    .busy(busy_a), .rd_busy(rd_busy_a), .any_busy(any_busy_a));

  rf_regfile_mp #(.WD(32), .NREG(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .issue_en(issue_en), .issue_addr(issue_addr),
    .busy(busy_b), .rd_busy(rd_busy_b), .any_busy(any_busy_b));

  // Configuration C: NREG=8, NRD=3, WD=16.
  logic        c_we, c_issue_en;
  logic [2:0]  c_waddr, c_issue_addr;
  logic [15:0] c_wdata;
  logic [8:0]  c_raddr;
  logic [47:0] c_rdata;
  logic [7:0]  c_busy;
  logic [2:0]  c_rd_busy;
  logic        c_any_busy;

  rf_regfile_mp #(.WD(16), .NREG(8), .NRD(3), .BYPASS(1), .ZERO_REG(1)) u_c (
    .clk(clk), .reset(reset), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .raddr(c_raddr), .rdata(c_rdata), .issue_en(c_issue_en), .issue_addr(c_issue_addr),
    .busy(c_busy), .rd_busy(c_rd_busy), .any_busy(c_any_busy));

  logic [15:0] m_mem [8];
  logic [7:0]  m_busy;

  task automatic idle_ab();
    we = 1'b0; issue_en = 1'b0; waddr = '0; issue_addr = '0; wdata = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_ab();
    raddr = {5'd0, 5'd5};
    c_we = 1'b0; c_issue_en = 1'b0; c_waddr = '0; c_issue_addr = '0;
    c_wdata = '0; c_raddr = '0;
    #1;
    check("reset_rdata_a", rdata_a, 64'h0);
    check("reset_busy_a", {32'h0, busy_a}, 64'h0);

    // Preload register 5 with data and a pending producer.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; issue_en = 1'b1; issue_addr = 5'd5;
    @(negedge clk);
    idle_ab();
    raddr = {5'd5, 5'd5};
    #1;
    check("preload_rdata5", {32'h0, rdata_a[31:0]}, 64'hDEADBEEF);
    check("preload_busy5", {63'h0, busy_a[5]}, 64'h1);
    // Reset dropped mid-cycle takes effect with no clock edge.
    #1 reset = 1'b0;
    #1;
    check("async_reset_rdata5", {32'h0, rdata_a[31:0]}, 64'h0);
    check("async_reset_busy", {32'h0, busy_a}, 64'h0);
    check("async_reset_any_busy", {63'h0, any_busy_a}, 64'h0);
    // A write attempted under reset is discarded, and bypass is masked too.
    we = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D; raddr = {5'd5, 5'd6};
    #1;
    check("reset_bypass_masked", rdata_a, 64'h0);
    @(negedge clk);
    idle_ab();
    reset = 1'b1;
    #1;
    check("reset_write_discarded", rdata_a, 64'h0);

    // Plain write then read on both ports.
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; raddr = {5'd0, 5'd0};
    @(negedge clk);
    idle_ab();
    raddr = {5'd3, 5'd3};
    #1;
    check("wr_rd_a", rdata_a, 64'h12345678_12345678);
    check("wr_rd_b", rdata_b, 64'h12345678_12345678);

    // Zero register: writes and issues are ignored.
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; issue_en = 1'b1; issue_addr = 5'd0;
    raddr = {5'd3, 5'd0};
    #1;
    check("zero_same_cycle", {32'h0, rdata_a[31:0]}, 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle_ab();
      #1;
      check($sformatf("zero_rdata_%0d", k), {32'h0, rdata_a[31:0]}, 64'h0);
      check($sformatf("zero_busy_%0d", k), {63'h0, busy_a[0]}, 64'h0);
      check($sformatf("zero_any_busy_%0d", k), {63'h0, any_busy_a}, 64'h0);
    end

    // Bypass vs. stored value.
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd3, 5'd7};
    #1;
    check("bypass_a", rdata_a, 64'h12345678_A5A5A5A5);
    check("no_bypass_b", rdata_b, 64'h12345678_00000000);
    @(negedge clk);
    idle_ab();
    #1;
    check("after_write_b", {32'h0, rdata_b[31:0]}, 64'hA5A5A5A5);

    // Scoreboard: issue 9, hold, write-back clears.
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd9; raddr = {5'd9, 5'd7};
    @(negedge clk);
    idle_ab();
    #1;
    check("issue_busy9", {63'h0, busy_a[9]}, 64'h1);
    check("issue_rd_busy", {62'h0, rd_busy_a}, 64'h2);
    check("issue_any_busy", {63'h0, any_busy_a}, 64'h1);
    repeat (3) @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000099;
    #1;
    check("wb_rd_busy_bypass_a", {62'h0, rd_busy_a}, 64'h0);
    check("wb_rd_busy_nobypass_b", {62'h0, rd_busy_b}, 64'h2);
    check("wb_busy_still_set", {63'h0, busy_a[9]}, 64'h1);
    @(negedge clk);
    idle_ab();
    #1;
    check("wb_busy_cleared", {63'h0, busy_a[9]}, 64'h0);
    check("wb_any_busy", {63'h0, any_busy_a}, 64'h0);

    // Issue and write on the same register: set wins.
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h00000077;
    #1;
    check("tie_rd_busy_not_masked", {62'h0, rd_busy_a}, 64'h0);
    @(negedge clk);
    idle_ab();
    #1;
    check("tie_busy_set", {63'h0, busy_a[9]}, 64'h1);
    check("tie_data_written", {32'h0, rdata_a[63:32]}, 64'h77);
    check("tie_rd_busy", {62'h0, rd_busy_a}, 64'h2);

    // Re-issue of a busy register, then a single write-back clears it.
    issue_en = 1'b1; issue_addr = 5'd9;
    @(negedge clk);
    idle_ab();
    #1;
    check("reissue_busy", {63'h0, busy_a[9]}, 64'h1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h0;
    @(negedge clk);
    idle_ab();
    #1;
    check("single_wb_clears", {63'h0, busy_a[9]}, 64'h0);

    // Concurrent issue and write-back on different registers.
    issue_en = 1'b1; issue_addr = 5'd10;
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd11; we = 1'b1; waddr = 5'd10; wdata = 32'h1;
    @(negedge clk);
    idle_ab();
    #1;
    check("concurrent_busy", {32'h0, busy_a}, 64'h0000_0800);
    check("write_nonbusy_busy_b", {32'h0, busy_b}, 64'h0000_0800);

    // Configuration C against a reference model.
    for (int r = 0; r < 8; r++) m_mem[r] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic [15:0] exp_rd;
      logic        exp_rb;
      logic [2:0]  ra;
      @(negedge clk);
      c_we         = ($urandom_range(0, 1) == 1);
      c_waddr      = 3'($urandom_range(0, 7));
      c_wdata      = 16'($urandom);
      c_issue_en   = ($urandom_range(0, 2) == 0);
      c_issue_addr = 3'($urandom_range(0, 7));
      c_raddr      = 9'($urandom);
      #1;
      for (int p = 0; p < 3; p++) begin
        ra = c_raddr[p*3 +: 3];
        exp_rd = m_mem[ra];
        if (c_we && c_waddr == ra && c_waddr != 3'd0) exp_rd = c_wdata;
        if (ra == 3'd0) exp_rd = '0;
        exp_rb = m_busy[ra] && !(c_we && c_waddr == ra &&
                                 !(c_issue_en && c_issue_addr == ra));
        check($sformatf("c_rdata%0d_cyc%0d", p, cyc), {48'h0, c_rdata[p*16 +: 16]}, {48'h0, exp_rd});
        check($sformatf("c_rd_busy%0d_cyc%0d", p, cyc), {63'h0, c_rd_busy[p]}, {63'h0, exp_rb});
      end
      check($sformatf("c_busy_cyc%0d", cyc), {56'h0, c_busy}, {56'h0, m_busy});
      check($sformatf("c_any_busy_cyc%0d", cyc), {63'h0, c_any_busy}, {63'h0, |m_busy});
      if (c_we && c_waddr != 3'd0) m_mem[c_waddr] = c_wdata;
      if (c_we)       m_busy[c_waddr]      = 1'b0;
      if (c_issue_en) m_busy[c_issue_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rf_regfile_mp
